// File: rtl/esn7e_demo_led_pwm.sv
// LED driver downstream of the green-LED PIO: global PWM brightness plus
// per-LED blinking, configured through a four-register Avalon-MM slave.
module esn7e_demo_led_pwm #(
  parameter int CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  led_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led_out
);

  localparam int              PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [7:0]      CNT_LAST = 8'd254;

  typedef enum logic [1:0] {
    ADDR_DUTY   = 2'd0,
    ADDR_BLINK  = 2'd1,
    ADDR_MASK   = 2'd2,
    ADDR_STATUS = 2'd3
  } reg_addr_e;

  logic [7:0]       r_duty;
  logic [7:0]       r_blink;
  logic [7:0]       r_mask;
  logic [PRE_W-1:0] r_pre;
  logic [7:0]       r_pwm_cnt;
  logic [7:0]       r_duty_act;
  logic [7:0]       r_bcnt;
  logic             r_blink_off;

  logic w_wr;
  logic w_wr_duty;
  logic w_wr_blink;
  logic w_wr_mask;
  logic w_tick;
  logic w_period_end;
  logic w_pwm_on;
  logic w_unused;

  assign w_wr       = chipselect && !write_n;
  assign w_wr_duty  = w_wr && (reg_addr_e'(address) == ADDR_DUTY);
  assign w_wr_blink = w_wr && (reg_addr_e'(address) == ADDR_BLINK);
  assign w_wr_mask  = w_wr && (reg_addr_e'(address) == ADDR_MASK);
  assign w_unused   = ^writedata[31:8];

  assign w_tick       = (r_pre == PRE_MAX);
  assign w_period_end = w_tick && (r_pwm_cnt == CNT_LAST);
  assign w_pwm_on     = (r_pwm_cnt < r_duty_act);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty  <= 8'hFF;
      r_blink <= 8'h00;
      r_mask  <= 8'h00;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      if (w_wr_duty)  r_duty  <= writedata[7:0];
      if (w_wr_blink) r_blink <= writedata[7:0];
      if (w_wr_mask)  r_mask  <= writedata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre      <= '0;
      r_pwm_cnt  <= '0;
      r_duty_act <= 8'hFF;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) r_pwm_cnt <= (r_pwm_cnt == CNT_LAST) ? 8'd0 : r_pwm_cnt + 8'd1;
      // A DUTY write landing on the period boundary is picked up immediately.
      if (w_period_end) r_duty_act <= w_wr_duty ? writedata[7:0] : r_duty;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcnt      <= '0;
      r_blink_off <= 1'b0;
    end else if (w_wr_blink || (r_blink == 8'h00)) begin
      r_bcnt      <= '0;
      r_blink_off <= 1'b0;
    end else if (w_period_end) begin
      if (r_bcnt == r_blink - 8'd1) begin
        r_bcnt      <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_bcnt <= r_bcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) led_out <= '0;
    else          led_out <= led_in & {8{w_pwm_on}} & ~(r_mask & {8{r_blink_off}});
  end

  always_comb begin
    readdata = '0; // NOTE: default first so no decode path can infer a latch.
    unique case (reg_addr_e'(address))
      ADDR_DUTY:   readdata[7:0] = r_duty;
      ADDR_BLINK:  readdata[7:0] = r_blink;
      ADDR_MASK:   readdata[7:0] = r_mask;
      ADDR_STATUS: readdata[15:0] = {r_pwm_cnt, 7'd0, r_blink_off};
    endcase
  end

endmodule

// File: tb/tb_esn7e_demo_led_pwm.sv
// Randomized bench for esn7e_demo_led_pwm; expected values come from an
// arithmetic model indexed by the number of clock edges since reset release.
module tb_esn7e_demo_led_pwm;

  localparam int D = 2;
  localparam int P = 255 * D;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  led_in = 8'h00;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [7:0]  led_out;

  always #5 clk = ~clk;

  esn7e_demo_led_pwm #(.CLK_DIV(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .led_in     (led_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  int total = 0;
  int bad   = 0;

  // Model state: edges since release, edge of last BLINK write, register copies.
  int         n;
  int         n0;
  logic [7:0] m_duty;
  logic [7:0] m_blink;
  logic [7:0] m_mask;
  logic [7:0] m_duty_act;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_cnt(input int k);
    return 8'((k / D) % 255);
  endfunction

  // Phase = number of period boundaries since the last BLINK write, in units of BLINK.
  function automatic logic m_off(input int k);
    if (m_blink == 8'h00) return 1'b0;
    return ((((k / P) - (n0 / P)) / int'(m_blink)) % 2) != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a, input int k);
    case (a)
      2'd0:    return {24'h0, m_duty};
      2'd1:    return {24'h0, m_blink};
      2'd2:    return {24'h0, m_mask};
      default: return {16'h0, m_cnt(k), 7'h0, m_off(k)};
    endcase
  endfunction

  task automatic model_reset();
    n = 0;
    n0 = 0;
    m_duty = 8'hFF;
    m_blink = 8'h00;
    m_mask = 8'h00;
    m_duty_act = 8'hFF;
  endtask

  task automatic step();
    logic [7:0] exp_led;
    logic       wr;
    exp_led = led_in & {8{m_cnt(n) < m_duty_act}} & ~(m_mask & {8{m_off(n)}});
    wr = chipselect && !write_n;
    @(posedge clk);
    n++;
    if (wr) begin
      case (address)
        2'd0: m_duty = writedata[7:0];
        2'd1: begin m_blink = writedata[7:0]; n0 = n; end
        2'd2: m_mask = writedata[7:0];
        default: ;
      endcase
    end
    if (n % P == 0) m_duty_act = m_duty;
    #1;
    check("led_out", {24'h0, led_out}, {24'h0, exp_led});
    check("readdata", readdata, m_read(address, n));
  endtask

  task automatic run(input int cycles, input bit rand_led);
    for (int i = 0; i < cycles; i++) begin
      if (rand_led) led_in = 8'($urandom);
      address = 2'($urandom_range(0, 3));
      step();
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    address = a;
    writedata = {24'($urandom), d};
    chipselect = 1'b1;
    write_n = 1'b0;
    step();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  initial begin
    bit found;
    model_reset();

    // Reset defaults
    led_in = 8'hA5;
    repeat (3) @(posedge clk);
    #3;
    check("led_out_in_reset", {24'h0, led_out}, 32'h0);
    reset_n = 1'b1;
    address = 2'd0; #1 check("rd_duty_rst", readdata, 32'hFF);
    address = 2'd1; #1 check("rd_blink_rst", readdata, 32'h0);
    address = 2'd2; #1 check("rd_mask_rst", readdata, 32'h0);
    run(5, 1'b0);

    // Duty 128, then extremes
    led_in = 8'hFF;
    bus_write(2'd0, 8'h80);
    run(3 * P, 1'b0);
    bus_write(2'd0, 8'h00);
    run(P + 20, 1'b1);
    bus_write(2'd0, 8'hFF);
    run(P + 20, 1'b1);

    // Blink on the low nibble
    led_in = 8'hFF;
    bus_write(2'd1, 8'd2);
    bus_write(2'd2, 8'h0F);
    bus_write(2'd0, 8'hFF);
    run(8 * P + 40, 1'b0);

    // BLINK rewrite on an edge that would otherwise toggle the phase
    found = 1'b0;
    for (int i = 0; i < 4 * P; i++) begin
      if (((n + 1) % P == 0) && (m_off(n + 1) != m_off(n))) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("collision_edge_found", {31'h0, found}, 32'h1);
    bus_write(2'd1, 8'd2);
    address = 2'd3;
    #1 check("status_after_collision", readdata, {16'h0, m_cnt(n), 8'h00});
    run(4 * P + 10, 1'b1);

    // Random register traffic
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        logic [1:0] a;
        a = 2'($urandom_range(0, 3));
        bus_write(a, (a == 2'd1) ? 8'($urandom_range(0, 3)) : 8'($urandom));
      end else begin
        led_in = 8'($urandom);
        address = 2'($urandom_range(0, 3));
        step();
      end
    end

    // Reset mid-period while blinked off
    led_in = 8'hFF;
    bus_write(2'd1, 8'd1);
    bus_write(2'd2, 8'h0F);
    bus_write(2'd0, 8'hFF);
    found = 1'b0;
    for (int i = 0; i < 4 * P; i++) begin
      if ((m_cnt(n) == 8'd100) && m_off(n)) begin
        found = 1'b1;
        break;
      end
      address = 2'($urandom_range(0, 3));
      step();
    end
    check("midreset_state_found", {31'h0, found}, 32'h1);
    check("led_out_before_reset", {24'h0, led_out}, 32'hF0);
    #2 reset_n = 1'b0;
    #1 check("led_out_async_reset", {24'h0, led_out}, 32'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    model_reset();
    address = 2'd3; #1 check("status_after_reset", readdata, 32'h0);
    address = 2'd0; #1 check("duty_after_reset", readdata, 32'hFF);
    run(P + 10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
